// File: rtl/mesi_pkg.sv
// MESI coherence encodings shared by mesi_next and mesi_fsm.
// Holds state, action, bus and mem codes plus the state and bus typedefs.
package mesi_pkg;

  typedef logic [1:0] mesi_state_t;
  typedef logic [1:0] mesi_bus_t;
  typedef logic [1:0] mesi_act_t;
  typedef logic [1:0] mesi_mem_t;

  localparam mesi_state_t ST_I = 2'b00;
  localparam mesi_state_t ST_S = 2'b01;
  localparam mesi_state_t ST_E = 2'b10;
  localparam mesi_state_t ST_M = 2'b11;

  localparam mesi_act_t ACT_RD_MISS = 2'b00;
  localparam mesi_act_t ACT_RD_HIT  = 2'b01;
  localparam mesi_act_t ACT_WR_MISS = 2'b10;
  localparam mesi_act_t ACT_WR_HIT  = 2'b11;

  localparam mesi_bus_t BUS_NONE    = 2'b00;
  localparam mesi_bus_t BUS_RD_MISS = 2'b01;
  localparam mesi_bus_t BUS_WR_MISS = 2'b10;
  localparam mesi_bus_t BUS_INVAL   = 2'b11;

  localparam mesi_mem_t MEM_NONE  = 2'b00;
  localparam mesi_mem_t MEM_FLUSH = 2'b01;
  localparam mesi_mem_t MEM_FETCH = 2'b10;

endpackage

// File: rtl/mesi_next.sv
// mesi_next: combinational MESI transition table (issuer and snooper).
// Ports: mode, action, shared_in, bus_msg, state_cur in;
//        bus_nxt, mem_nxt, st_nxt out.
// Build option: MESI_SHARED_SUPPLY_EN lets an S snooper supply data.
module mesi_next
  import mesi_pkg::*;
(
  input  logic        mode,
  input  mesi_act_t   action,
  input  logic        shared_in,
  input  mesi_bus_t   bus_msg,
  input  mesi_state_t state_cur,
  output mesi_bus_t   bus_nxt,
  output mesi_mem_t   mem_nxt,
  output mesi_state_t st_nxt
);

  logic is_i;
  logic is_m;
  logic rd_hit;
  logic rd_miss;
  logic wr_hit;
  logic wr_miss;
  mesi_mem_t s_supply;

  assign is_i = (state_cur == ST_I);
  assign is_m = (state_cur == ST_M);

  // A hit on an invalid line is really a miss.
  assign rd_hit  = (action == ACT_RD_HIT) && !is_i;
  assign rd_miss = (action == ACT_RD_MISS)
                || ((action == ACT_RD_HIT) && is_i);
  assign wr_hit  = (action == ACT_WR_HIT) && !is_i;
  assign wr_miss = (action == ACT_WR_MISS)
                || ((action == ACT_WR_HIT) && is_i);

`ifdef MESI_SHARED_SUPPLY_EN
  assign s_supply = MEM_FLUSH;
`else
  assign s_supply = MEM_NONE;
`endif

  always_comb begin
    bus_nxt = BUS_NONE;
    mem_nxt = MEM_NONE;
    st_nxt  = state_cur;
    if (mode) begin
      unique case (1'b1)
        rd_hit: ;
        rd_miss: begin
          bus_nxt = BUS_RD_MISS;
          st_nxt  = shared_in ? ST_S : ST_E;
          if (is_m)
            mem_nxt = MEM_FLUSH;
          else
            mem_nxt = shared_in ? MEM_NONE
                                : MEM_FETCH;
        end
        wr_hit: begin
          st_nxt = ST_M;
          if (state_cur == ST_S)
            bus_nxt = BUS_INVAL;
        end
        wr_miss: begin
          bus_nxt = BUS_WR_MISS;
          st_nxt  = ST_M;
          if (is_m)
            mem_nxt = MEM_FLUSH;
        end
        default: ;
      endcase
    end else if (!is_i) begin
      unique case (bus_msg)
        BUS_RD_MISS: begin
          st_nxt = ST_S;
          if (state_cur == ST_S)
            mem_nxt = s_supply;
          else
            mem_nxt = MEM_FLUSH;
        end
        BUS_WR_MISS: begin
          st_nxt = ST_I;
          if (is_m)
            mem_nxt = MEM_FLUSH;
        end
        BUS_INVAL: st_nxt = ST_I;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mesi_fsm.sv
// mesi_fsm: per-line MESI controller with registered results.
// Ports: clock, clear (sync active-low), ctrl {mode,action,shared_in},
//        bus_msg, state_cur in; bus_out, mem_out, state_nxt out.
// Build option: MESI_SHARED_SUPPLY_EN (see mesi_next).
module mesi_fsm
  import mesi_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [3:0]  ctrl,
  input  mesi_bus_t   bus_msg,
  input  mesi_state_t state_cur,
  output mesi_bus_t   bus_out,
  output mesi_mem_t   mem_out,
  output mesi_state_t state_nxt
);

  mesi_bus_t   bus_c;
  mesi_mem_t   mem_c;
  mesi_state_t st_c;

  mesi_next u_next (
    .mode      (ctrl[3]),
    .action    (ctrl[2:1]),
    .shared_in (ctrl[0]),
    .bus_msg   (bus_msg),
    .state_cur (state_cur),
    .bus_nxt   (bus_c),
    .mem_nxt   (mem_c),
    .st_nxt    (st_c)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      bus_out   <= BUS_NONE;
      mem_out   <= MEM_NONE;
      state_nxt <= ST_I;
    end else begin
      bus_out   <= bus_c;
      mem_out   <= mem_c;
      state_nxt <= st_c;
    end
  end

endmodule

// File: tb/tb_mesi_fsm.sv
// Testbench for mesi_fsm: directed table, hand sequences, random vs model.
module tb_mesi_fsm;

`ifdef MESI_SHARED_SUPPLY_EN
  localparam logic [1:0] S_SUP = 2'b01;
`else
  localparam logic [1:0] S_SUP = 2'b00;
`endif

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] ctrl;
  logic [1:0] bus_msg;
  logic [1:0] state_cur;
  logic [1:0] bus_out;
  logic [1:0] mem_out;
  logic [1:0] state_nxt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mesi_fsm dut (
    .clock     (clock),
    .clear     (clear),
    .ctrl      (ctrl),
    .bus_msg   (bus_msg),
    .state_cur (state_cur),
    .bus_out   (bus_out),
    .mem_out   (mem_out),
    .state_nxt (state_nxt)
  );

  typedef struct {
    string      name;
    logic       mode;
    logic [1:0] act;
    logic       sh;
    logic [1:0] bus;
    logic [1:0] st;
    logic [1:0] e_bus;
    logic [1:0] e_mem;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm,
                     input logic [1:0] got,
                     input logic [1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk3(input string nm,
                      input logic [1:0] eb,
                      input logic [1:0] em,
                      input logic [1:0] es);
    chk({nm, ".bus"}, bus_out, eb);
    chk({nm, ".mem"}, mem_out, em);
    chk({nm, ".st"}, state_nxt, es);
  endtask

  // Reference: reasons about valid/dirty/hit rather than state codes.
  function automatic void model(
    input  logic       clr,
    input  logic       m,
    input  logic [1:0] a,
    input  logic       sh,
    input  logic [1:0] b,
    input  logic [1:0] s,
    output logic [1:0] eb,
    output logic [1:0] em,
    output logic [1:0] es);
    int  st;
    bit  valid;
    bit  dirty;
    bit  wr;
    bit  hit;
    st    = int'(s);
    valid = (st != 0);
    dirty = (st == 3);
    eb = 2'd0;
    em = 2'd0;
    es = s;
    if (!clr) begin
      es = 2'd0;
    end else if (m) begin
      wr  = a[1];
      hit = a[0] && valid;
      if (!wr) begin
        if (!hit) begin
          eb = 2'd1;
          es = sh ? 2'd1 : 2'd2;
          em = dirty ? 2'd1 : (sh ? 2'd0 : 2'd2);
        end
      end else if (hit) begin
        es = 2'd3;
        eb = (st == 1) ? 2'd3 : 2'd0;
      end else begin
        eb = 2'd2;
        es = 2'd3;
        em = dirty ? 2'd1 : 2'd0;
      end
    end else if (valid) begin
      if (b == 2'd1) begin
        es = 2'd1;
        em = (st >= 2) ? 2'd1 : S_SUP;
      end else if (b == 2'd2) begin
        es = 2'd0;
        em = dirty ? 2'd1 : 2'd0;
      end else if (b == 2'd3) begin
        es = 2'd0;
      end
    end
  endfunction

  task automatic drive(input logic clr, input vec_t v);
    clear     = clr;
    ctrl      = {v.mode, v.act, v.sh};
    bus_msg   = v.bus;
    state_cur = v.st;
  endtask

  initial begin
    logic [1:0] eb, em, es;
    vec_t v;
    vecs[0]  = '{"iss_rdmiss_I_sh0", 1, 2'd0, 0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
    vecs[1]  = '{"iss_rdmiss_I_sh1", 1, 2'd0, 1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
    vecs[2]  = '{"iss_wrhit_S", 1, 2'd3, 0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
    vecs[3]  = '{"iss_wrhit_E", 1, 2'd3, 1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3};
    vecs[4]  = '{"snp_rdmiss_M", 0, 2'd3, 1, 2'd1, 2'd3, 2'd0, 2'd1, 2'd1};
    vecs[5]  = '{"snp_rdmiss_S", 0, 2'd0, 0, 2'd1, 2'd1, 2'd0, S_SUP, 2'd1};
    vecs[6]  = '{"snp_wrmiss_M", 0, 2'd1, 0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
    vecs[7]  = '{"snp_inval_E", 0, 2'd2, 1, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
    vecs[8]  = '{"iss_wrmiss_M", 1, 2'd2, 0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3};
    vecs[9]  = '{"iss_rdhit_I", 1, 2'd1, 0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    vecs[10] = '{"iss_wrhit_I", 1, 2'd3, 0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd3};
    vecs[11] = '{"iss_rdmiss_M", 1, 2'd0, 1, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1};
    vecs[12] = '{"iss_rdhit_E", 1, 2'd1, 0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd2};
    vecs[13] = '{"snp_I_rdmiss", 0, 2'd0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

    // Reset with arbitrary inputs: result must be all zero.
    v = '{"rst", 1, 2'd2, 0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0};
    drive(1'b0, v);
    @(posedge clock);
    #1 chk3("reset", 2'd0, 2'd0, 2'd0);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(1'b1, vecs[i]);
      @(posedge clock);
      #1 chk3(vecs[i].name, vecs[i].e_bus,
              vecs[i].e_mem, vecs[i].e_st);
    end

    // One-clock latency: new inputs must not show before the edge.
    @(negedge clock);
    drive(1'b1, vecs[8]);
    @(posedge clock);
    #1;
    @(negedge clock);
    drive(1'b1, vecs[0]);
    #1 chk3("lat_hold", 2'd2, 2'd1, 2'd3);
    @(posedge clock);
    #1 chk3("lat_new", 2'd1, 2'd2, 2'd2);

    // Reset mid-operation overrides the pending result.
    @(negedge clock);
    drive(1'b0, vecs[4]);
    @(posedge clock);
    #1 chk3("rst_mid", 2'd0, 2'd0, 2'd0);

    // Random stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      logic clr;
      @(negedge clock);
      clr = ($urandom_range(0, 15) != 0);
      v.mode = 1'($urandom_range(0, 1));
      v.act  = 2'($urandom_range(0, 3));
      v.sh   = 1'($urandom_range(0, 1));
      v.bus  = 2'($urandom_range(0, 3));
      v.st   = 2'($urandom_range(0, 3));
      drive(clr, v);
      model(clr, v.mode, v.act, v.sh, v.bus, v.st,
            eb, em, es);
      @(posedge clock);
      #1 chk3("rand", eb, em, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
